// File: rtl/serial_frame_serializer.sv
// Parallel-to-serial frame transmitter: preamble, data MSB first, then an idle gap.
// Drives the serial data_in of the downstream 4-bit shift register, one bit per clock.
module serial_frame_serializer #(
   parameter int                      WIDTH        = 8,
   parameter int                      PREAMBLE_LEN = 4,
   parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = 4'b1010,
   parameter int                      GAP_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             serial_out,
   output logic             frame_active,
   output logic             frame_done,
   output logic [1:0]       state_dbg
);

   localparam int MAX_PW  = (PREAMBLE_LEN > WIDTH) ? PREAMBLE_LEN : WIDTH;
   localparam int MAX_LEN = (MAX_PW > GAP_CYCLES) ? MAX_PW : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_GAP      = 2'd3
   } state_t;

   // Handshake: a word transfers on a rising edge where in_valid && in_ready.
   // in_ready depends only on registered state (and reset), never on in_valid.
   // The upstream holds in_data stable until that edge; nothing is queued.

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0]        hold_q, hold_d;
   logic [PREAMBLE_LEN-1:0] pre_q, pre_d;
   logic                    ser_d, act_d, done_d;

   assign cnt_inc   = cnt_q + 1'b1;
   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign state_dbg = state_q;

   // The state names what serial_out will carry in the cycle after this edge's decision;
   // both the bit and its framing flags are computed here and registered together.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      pre_d   = pre_q;
      ser_d   = 1'b0;
      act_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_PREAMBLE;
               cnt_d   = '0;
               hold_d  = in_data;
               ser_d   = PREAMBLE[PREAMBLE_LEN-1];
               pre_d   = PREAMBLE << 1;
               act_d   = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            act_d = 1'b1;
            if (cnt_q == PRE_LAST) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               ser_d   = hold_q[WIDTH-1];
               hold_d  = hold_q << 1;
               done_d  = (DATA_LAST == '0);
            end else begin
               cnt_d = cnt_inc;
               ser_d = pre_q[PREAMBLE_LEN-1];
               pre_d = pre_q << 1;
            end
         end
         ST_DATA: begin
            if (cnt_q == DATA_LAST) begin
               state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d  = cnt_inc;
               ser_d  = hold_q[WIDTH-1];
               hold_d = hold_q << 1;
               act_d  = 1'b1;
               done_d = (cnt_inc == DATA_LAST);
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         hold_q       <= '0;
         pre_q        <= '0;
         serial_out   <= 1'b0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         pre_q        <= pre_d;
         serial_out   <= ser_d;
         frame_active <= act_d;
         frame_done   <= done_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_serializer.sv
// Bench for serial_frame_serializer: directed frame checks, a random run against a
// queue-based frame model, and a minimal-parameter corner instance.
module tb_serial_frame_serializer;

   localparam int W = 8;
   localparam int P = 4;
   localparam int G = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, in_valid;
   logic [W-1:0] in_data;
   logic         in_ready, serial_out, frame_active, frame_done;
   logic [1:0]   state_dbg;

   logic         valid_c;
   logic [0:0]   data_c;
   logic         ready_c, ser_c, act_c, done_c;
   logic [1:0]   state_dbg_c;

   int checks = 0;
   int errors = 0;

   serial_frame_serializer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .serial_out(serial_out), .frame_active(frame_active),
      .frame_done(frame_done), .state_dbg(state_dbg)
   );

   serial_frame_serializer #(
      .WIDTH(1), .PREAMBLE_LEN(1), .PREAMBLE(1'b1), .GAP_CYCLES(0)
   ) dut_c (
      .clk(clk), .reset(reset), .in_valid(valid_c), .in_data(data_c),
      .in_ready(ready_c), .serial_out(ser_c), .frame_active(act_c),
      .frame_done(done_c), .state_dbg(state_dbg_c)
   );

   // Frame model: each accepted word becomes a list of {serial, active, done} cycles.
   logic [2:0]   exp_q[$];
   logic         exp_ser, exp_act, exp_done, exp_busy;
   logic [P-1:0] pre_pat = 4'b1010;
   logic [3:0]   sr = 4'b0000;

   always @(posedge clk) begin
      logic [2:0] e;
      if (reset) begin
         exp_q.delete();
         exp_ser  <= 1'b0;
         exp_act  <= 1'b0;
         exp_done <= 1'b0;
         exp_busy <= 1'b0;
      end else begin
         if (!exp_busy && exp_q.size() == 0 && in_valid) begin
            for (int i = 0; i < P; i++) exp_q.push_back({pre_pat[P-1-i], 1'b1, 1'b0});
            for (int i = 0; i < W; i++) exp_q.push_back({in_data[W-1-i], 1'b1, 1'(i == W-1)});
            for (int i = 0; i < G; i++) exp_q.push_back(3'b000);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_ser  <= e[2];
            exp_act  <= e[1];
            exp_done <= e[0];
            exp_busy <= 1'b1;
         end else begin
            exp_ser  <= 1'b0;
            exp_act  <= 1'b0;
            exp_done <= 1'b0;
            exp_busy <= 1'b0;
         end
      end
   end

   // Downstream 4-bit shift register fed by serial_out.
   always @(posedge clk) sr <= {sr[2:0], serial_out};

   function automatic logic exp_ready_f();
      return !exp_busy && (exp_q.size() == 0) && !reset;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if ({in_ready, serial_out, frame_active} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: rdy/ser/act got %b want 000", k,
                     {in_ready, serial_out, frame_active});
         end
      end
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      checks++;
      if ({serial_out, frame_active, frame_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release_outputs: got %b want 000",
                  {serial_out, frame_active, frame_done});
      end
   endtask

   task automatic test_single_frame();
      logic [11:0] pat = 12'b1010_1010_0101;
      logic want_ser;
      in_valid = 1'b1; in_data = 8'hA5;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_pre_ready: got %b want 1", in_ready);
      end
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         want_ser = (k <= 12) ? pat[12-k] : 1'b0;
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !==
             {want_ser, 1'(k <= 12), 1'(k == 12), 1'(k == 15)}) begin
            errors++;
            $display("FAIL single_a5 N+%0d: ser/act/done/rdy got %b want %b", k,
                     {serial_out, frame_active, frame_done, in_ready},
                     {want_ser, 1'(k <= 12), 1'(k == 12), 1'(k == 15)});
         end
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !==
             {exp_ser, exp_act, exp_done, exp_ready_f()}) begin
            errors++;
            $display("FAIL model_single N+%0d: got %b want %b", k,
                     {serial_out, frame_active, frame_done, in_ready},
                     {exp_ser, exp_act, exp_done, exp_ready_f()});
         end
         if (k == 5 || k == 9 || k == 13) begin
            checks++;
            if (sr !== ((k == 13) ? 4'b0101 : 4'b1010)) begin
               errors++;
               $display("FAIL shift_reg N+%0d: got %b want %b", k, sr,
                        (k == 13) ? 4'b0101 : 4'b1010);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      logic obs[64];
      logic [7:0] w1 = 8'h3C;
      logic [7:0] w2 = 8'hC3;
      t1 = -1; t2 = -1;
      in_valid = 1'b1; in_data = w1;
      for (int i = 0; i < 45; i++) begin
         if (in_ready && in_valid) begin
            if (t1 < 0) t1 = i;
            else if (t2 < 0) t2 = i;
         end
         @(posedge clk); @(negedge clk);
         obs[i] = serial_out;
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !==
             {exp_ser, exp_act, exp_done, exp_ready_f()}) begin
            errors++;
            $display("FAIL model_b2b iter %0d: got %b want %b", i,
                     {serial_out, frame_active, frame_done, in_ready},
                     {exp_ser, exp_act, exp_done, exp_ready_f()});
         end
         if (t1 >= 0) in_data = w2;
         if (t2 >= 0) in_valid = 1'b0;
      end
      checks++;
      if (t1 < 0 || t2 < 0 || t2 - t1 != 15) begin
         errors++;
         $display("FAIL b2b_spacing: got first=%0d second=%0d want spacing 15", t1, t2);
      end
      if (t1 >= 0 && t2 >= 0) begin
         for (int b = 0; b < 8; b++) begin
            checks++;
            if (obs[t1+4+b] !== w1[7-b] || obs[t2+4+b] !== w2[7-b]) begin
               errors++;
               $display("FAIL b2b_data bit %0d: got %b/%b want %b/%b", b,
                        obs[t1+4+b], obs[t2+4+b], w1[7-b], w2[7-b]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      in_valid = 1'b1; in_data = 8'hFF;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); @(negedge clk);
         if (k == 1) in_valid = 1'b0;
      end
      checks++;
      if ({serial_out, frame_active} !== 2'b11) begin
         errors++;
         $display("FAIL mid_third_bit: ser/act got %b want 11", {serial_out, frame_active});
      end
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({serial_out, frame_active, frame_done, in_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_abort: ser/act/done/rdy got %b want 0000",
                  {serial_out, frame_active, frame_done, in_ready});
      end
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_after cycle %0d: got %b want 0001", k,
                     {serial_out, frame_active, frame_done, in_ready});
         end
      end
      in_valid = 1'b1; in_data = 8'h01;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !==
             {exp_ser, exp_act, exp_done, exp_ready_f()}) begin
            errors++;
            $display("FAIL model_after_abort N+%0d: got %b want %b", k,
                     {serial_out, frame_active, frame_done, in_ready},
                     {exp_ser, exp_act, exp_done, exp_ready_f()});
         end
         if (k >= 5 && k <= 12) begin
            checks++;
            if (serial_out !== 1'(k == 12)) begin
               errors++;
               $display("FAIL after_abort_data N+%0d: got %b want %b", k, serial_out, 1'(k == 12));
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         reset    = ($urandom_range(0, 79) == 0);
         @(posedge clk); @(negedge clk);
         checks++;
         if ({serial_out, frame_active, frame_done, in_ready} !==
             {exp_ser, exp_act, exp_done, exp_ready_f()}) begin
            errors++;
            $display("FAIL model_random iter %0d: got %b want %b", i,
                     {serial_out, frame_active, frame_done, in_ready},
                     {exp_ser, exp_act, exp_done, exp_ready_f()});
         end
      end
      reset = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL random_drain_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_corner();
      logic [3:0] want;
      valid_c = 1'b1; data_c = 1'b1;
      checks++;
      if (ready_c !== 1'b1) begin
         errors++;
         $display("FAIL corner_pre_ready: got %b want 1", ready_c);
      end
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); @(negedge clk);
         case (k % 3)
            1:       want = 4'b1100;
            2:       want = 4'b1110;
            default: want = 4'b0001;
         endcase
         checks++;
         if ({ser_c, act_c, done_c, ready_c} !== want) begin
            errors++;
            $display("FAIL corner N+%0d: ser/act/done/rdy got %b want %b", k,
                     {ser_c, act_c, done_c, ready_c}, want);
         end
      end
      valid_c = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      valid_c = 1'b0; data_c = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      test_corner();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/serial_frame_serializer.md
# serial_frame_serializer

Parallel-to-serial transmitter that feeds the serial `data_in` of the 4-bit shift-register stage. Accepts WIDTH-bit words over a valid/ready handshake. Emits each word as one serial frame: a fixed preamble, then the data bits MSB first, then an idle gap. It drives one bit per clock, so the downstream shift register sees the earliest bit in its MSB after four shifts.

## Interface
- `WIDTH`, default 8: data word width; must be ≥ 1.
- `PREAMBLE_LEN`, default 4: number of preamble bits; must be ≥ 1.
- `PREAMBLE`, default 4'b1010: preamble pattern, PREAMBLE_LEN bits, sent MSB first.
- `GAP_CYCLES`, default 2: idle cycles after the last data bit; must be ≥ 0.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: word-available strobe.
- `in_data` input WIDTH: word to transmit.
- `in_ready` output 1: block can accept a word this cycle.
- `serial_out` output 1: serial bit stream; connects to the shift register `data_in`.
- `frame_active` output 1: high while `serial_out` carries a preamble or data bit.
- `frame_done` output 1: one-cycle pulse coincident with the last data bit on `serial_out`.

## Operation
- Clock and reset: one clock domain; reset is synchronous and active-high.
- State machine states are IDLE, PREAMBLE, DATA and GAP.
- IDLE:
  - `in_ready`=1 and `serial_out`=0.
  - When `in_valid && in_ready`, capture `in_data` into the shift holding register and go to PREAMBLE.
- PREAMBLE: drive PREAMBLE bits MSB first, one per cycle, for PREAMBLE_LEN cycles, then go to DATA.
- DATA:
  - Drive the captured word MSB first, one bit per cycle, for WIDTH cycles.
  - On the last bit, go to GAP if GAP_CYCLES > 0, else go to IDLE.
- GAP: `serial_out`=0 for GAP_CYCLES cycles, then go to IDLE.
- `in_ready` is high only in IDLE. It is a pure decode of registered state, with no combinational path from `in_valid`.
- While `in_ready`=0, `in_data` and `in_valid` are ignored. There is no queueing; the upstream block holds its word until accepted.
- Bit counter width is clog2(max(PREAMBLE_LEN, WIDTH, GAP_CYCLES)+1). It resets to 0 on entry to each state and never wraps inside a state.
- `serial_out`, `frame_active` and `frame_done` are registered outputs.

## Timing
- Reset values, forced on the edge where `reset`=1:
  - state = IDLE
  - `serial_out`=0, `frame_active`=0, `frame_done`=0
  - holding register cleared
- `in_ready` during and after reset:
  - `in_ready`=0 in any cycle where `reset` is high.
  - `in_ready`=1 from the first cycle after `reset` deasserts.
- Accept on cycle N (`in_valid && in_ready` at edge N):
  - Preamble bits appear on `serial_out` in cycles N+1 … N+PREAMBLE_LEN.
  - Data bits appear in cycles N+PREAMBLE_LEN+1 … N+PREAMBLE_LEN+WIDTH.
  - `frame_done`=1 in cycle N+PREAMBLE_LEN+WIDTH only.
  - Gap occupies cycles through N+PREAMBLE_LEN+WIDTH+GAP_CYCLES.
  - `in_ready`=1 again in cycle N+PREAMBLE_LEN+WIDTH+GAP_CYCLES+1.
- Frame-to-frame spacing:
  - Minimum spacing between accepts is PREAMBLE_LEN+WIDTH+GAP_CYCLES+1 cycles.
  - With GAP_CYCLES=0 there is still exactly one IDLE cycle (`serial_out`=0) between frames.
- `frame_active` is high for exactly PREAMBLE_LEN+WIDTH consecutive cycles per frame.
- Reset mid-frame (any state):
  - The frame is aborted and the word discarded.
  - Next cycle: `serial_out`=0, `frame_active`=0.
  - `frame_done` does not pulse for the aborted frame.
- Reset and `in_valid` in the same cycle: reset wins; no capture.
- `in_valid` held high continuously: one word is accepted per frame. The word captured is the `in_data` value at the accepting edge.

## Test plan
- Reset behaviour: reset high 3 cycles with `in_valid`=1 and `in_data`=8'hFF.
  - Required: `in_ready`=0, `serial_out`=0, `frame_active`=0 throughout.
  - Required: `in_ready`=1 on the first cycle after release.
- Single frame with defaults: accept 8'hA5 at cycle N.
  - Required `serial_out` for cycles N+1…N+12: 1,0,1,0,1,0,1,0,0,1,0,1.
  - Required: `frame_done` high at N+12 only; `serial_out`=0 at N+13 and N+14; `in_ready`=1 at N+15.
- Downstream check: connect to the 4-bit shift register and send 8'hA5.
  - Required shift-register outputs: 4'b1010 at N+5, 4'b1010 at N+9, 4'b0101 at N+13.
- Back-to-back frames: `in_valid` held high, `in_data`=8'h3C then 8'hC3.
  - Required: second accept exactly 15 cycles after the first.
  - Required: second frame data bits are 1,1,0,0,0,0,1,1.
- Reset mid-frame: assert reset at the 3rd data bit of 8'hFF.
  - Required: `serial_out`=0 and `frame_active`=0 next cycle, with no `frame_done`.
  - Required: a following 8'h01 frame transmits cleanly.
- Parameter corner: GAP_CYCLES=0, WIDTH=1, PREAMBLE_LEN=1, PREAMBLE=1'b1, continuous `in_valid` with data 1.
  - Required `serial_out` pattern: 1,1,0 repeating, with an accept every 3 cycles.
